// File: rtl/rx_frame_decoder.sv
// rtl/rx_frame_decoder.sv - framed UART byte decoder with escape, checksum, timeout and held-message handshake
module rx_frame_decoder #(
   parameter int unsigned MAX_BYTES      = 10,
   parameter logic [7:0]  SYNC_BYTE      = 8'h7E,
   parameter logic [7:0]  ESC_BYTE       = 8'hFE,
   parameter logic [7:0]  END_BYTE       = 8'h03,
   parameter bit          CHECKSUM_EN    = 1'b0,
   parameter int unsigned TIMEOUT_CYCLES = 100
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [7:0]             in_data,
   input  logic                   in_valid,
   output logic [8*MAX_BYTES-1:0] msg_data,
   output logic [7:0]             msg_len,
   output logic                   msg_valid,
   input  logic                   msg_ack,
   output logic                   err_valid,
   output logic [2:0]             err_code,
   output logic                   busy
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   typedef enum logic [2:0] {S_IDLE, S_BCNT, S_BODY, S_CSUM, S_TAIL} state_t;

   localparam state_t S_AFTER_BODY = CHECKSUM_EN ? S_CSUM : S_TAIL;

   state_t                   state_q, state_d;
   logic                     esc_q, esc_d;
   logic [8*MAX_BYTES-1:0]   work_q, work_d;
   logic [7:0]               rcvd_q, rcvd_d;
   logic [7:0]               cnt_q, cnt_d;
   logic [7:0]               csum_q, csum_d;
   logic [TW-1:0]            tmo_q, tmo_d;
   logic [8*MAX_BYTES-1:0]   msg_data_q, msg_data_d;
   logic [7:0]               msg_len_q, msg_len_d;
   logic                     msg_valid_q, msg_valid_d;
   logic                     err_valid_q, err_valid_d;
   logic [2:0]               err_code_q, err_code_d;
   logic [6:1]               err_vec;
   logic                     complete;

   always_comb begin
      state_d     = state_q;
      esc_d       = esc_q;
      work_d      = work_q;
      rcvd_d      = rcvd_q;
      cnt_d       = cnt_q;
      csum_d      = csum_q;
      tmo_d       = tmo_q;
      msg_data_d  = msg_data_q;
      msg_len_d   = msg_len_q;
      msg_valid_d = msg_valid_q;
      err_vec     = '0;
      complete    = 1'b0;
      err_valid_d = 1'b0;
      err_code_d  = 3'd0;

      if (in_valid) begin
         tmo_d = '0;
         if (!esc_q && in_data == SYNC_BYTE) begin
            if (state_q != S_IDLE) err_vec[5] = 1'b1;
            state_d = S_BCNT;
            work_d  = '0;
            rcvd_d  = 8'd0;
            cnt_d   = 8'd0;
            csum_d  = 8'd0;
         end else if (!esc_q && in_data == ESC_BYTE) begin
            // Escape has no meaning outside a frame, so IDLE leaves the flag clear
            if (state_q != S_IDLE) esc_d = 1'b1;
         end else begin
            esc_d = 1'b0;
            case (state_q)
               S_BCNT: begin
                  cnt_d  = in_data;
                  csum_d = csum_q + in_data;
                  if (in_data > 8'(MAX_BYTES)) begin
                     err_vec[1] = 1'b1;
                     state_d    = S_IDLE;
                  end else if (in_data == 8'd0) begin
                     state_d = S_AFTER_BODY;
                  end else begin
                     state_d = S_BODY;
                  end
               end
               S_BODY: begin
                  for (int i = 0; i < int'(MAX_BYTES); i++)
                     if (rcvd_q == 8'(i)) work_d[8*i +: 8] = in_data;
                  rcvd_d = rcvd_q + 8'd1;
                  csum_d = csum_q + in_data;
                  if (rcvd_q + 8'd1 == cnt_q) state_d = S_AFTER_BODY;
               end
               S_CSUM: begin
                  if (in_data != csum_q) begin
                     err_vec[2] = 1'b1;
                     state_d    = S_IDLE;
                  end else begin
                     state_d = S_TAIL;
                  end
               end
               S_TAIL: begin
                  if (in_data != END_BYTE) err_vec[3] = 1'b1;
                  else                     complete   = 1'b1;
                  state_d = S_IDLE;
               end
               default: ;
            endcase
         end
      end else if (TIMEOUT_CYCLES != 0 && state_q != S_IDLE) begin
         if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            err_vec[4] = 1'b1;
            state_d    = S_IDLE;
            esc_d      = 1'b0;
            tmo_d      = '0;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end

      if (msg_valid_q && msg_ack) msg_valid_d = 1'b0;
      // A completed frame replaces the held one only if the slot is free or freed this cycle
      if (complete) begin
         if (!msg_valid_q || msg_ack) begin
            msg_data_d  = work_d;
            msg_len_d   = cnt_q;
            msg_valid_d = 1'b1;
         end else begin
            err_vec[6] = 1'b1;
         end
      end

      err_valid_d = |err_vec;
      for (int i = 6; i >= 1; i--)
         if (err_vec[i]) err_code_d = 3'(i);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         esc_q       <= 1'b0;
         work_q      <= '0;
         rcvd_q      <= 8'd0;
         cnt_q       <= 8'd0;
         csum_q      <= 8'd0;
         tmo_q       <= '0;
         msg_data_q  <= '0;
         msg_len_q   <= 8'd0;
         msg_valid_q <= 1'b0;
         err_valid_q <= 1'b0;
         err_code_q  <= 3'd0;
      end else begin
         state_q     <= state_d;
         esc_q       <= esc_d;
         work_q      <= work_d;
         rcvd_q      <= rcvd_d;
         cnt_q       <= cnt_d;
         csum_q      <= csum_d;
         tmo_q       <= tmo_d;
         msg_data_q  <= msg_data_d;
         msg_len_q   <= msg_len_d;
         msg_valid_q <= msg_valid_d;
         err_valid_q <= err_valid_d;
         err_code_q  <= err_code_d;
      end
   end

   assign msg_data  = msg_data_q;
   assign msg_len   = msg_len_q;
   assign msg_valid = msg_valid_q;
   assign err_valid = err_valid_q;
   assign err_code  = err_code_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_rx_frame_decoder.sv
// tb/tb_rx_frame_decoder.sv - directed self-checking bench for rx_frame_decoder
module tb_rx_frame_decoder;

   logic        clk = 1'b0;
   logic        reset = 1'b0;

   logic [7:0]  in_data = 8'd0;
   logic        in_valid = 1'b0;
   logic [79:0] msg_data;
   logic [7:0]  msg_len;
   logic        msg_valid;
   logic        msg_ack = 1'b0;
   logic        err_valid;
   logic [2:0]  err_code;
   logic        busy;

   logic [7:0]  c_in_data = 8'd0;
   logic        c_in_valid = 1'b0;
   logic [79:0] c_msg_data;
   logic [7:0]  c_msg_len;
   logic        c_msg_valid;
   logic        c_msg_ack = 1'b0;
   logic        c_err_valid;
   logic [2:0]  c_err_code;
   logic        c_busy;

   int checks = 0;
   int failures = 0;
   int seq_errs = 0;
   logic [2:0] seq_last = 3'd0;

   rx_frame_decoder #(.MAX_BYTES(10), .CHECKSUM_EN(1'b0), .TIMEOUT_CYCLES(100)) u_dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .msg_data(msg_data), .msg_len(msg_len), .msg_valid(msg_valid), .msg_ack(msg_ack),
      .err_valid(err_valid), .err_code(err_code), .busy(busy));

   rx_frame_decoder #(.MAX_BYTES(10), .CHECKSUM_EN(1'b1), .TIMEOUT_CYCLES(100)) u_cs (
      .clk(clk), .reset(reset), .in_data(c_in_data), .in_valid(c_in_valid),
      .msg_data(c_msg_data), .msg_len(c_msg_len), .msg_valid(c_msg_valid), .msg_ack(c_msg_ack),
      .err_valid(c_err_valid), .err_code(c_err_code), .busy(c_busy));

   always #5 clk = ~clk;

   task automatic send_byte(input bit cs, input logic [7:0] b);
      @(negedge clk);
      if (cs) begin c_in_data = b; c_in_valid = 1'b1; end
      else    begin in_data = b;   in_valid = 1'b1;   end
      @(negedge clk);
      c_in_valid = 1'b0;
      in_valid   = 1'b0;
      if (cs ? c_err_valid : err_valid) begin
         seq_errs++;
         seq_last = cs ? c_err_code : err_code;
      end
   endtask

   task automatic send_seq(input bit cs, input logic [95:0] v, input int n);
      for (int i = 0; i < n; i++) send_byte(cs, v[8*(n-1-i) +: 8]);
   endtask

   task automatic do_ack(input bit cs);
      @(negedge clk);
      if (cs) c_msg_ack = 1'b1; else msg_ack = 1'b1;
      @(negedge clk);
      c_msg_ack = 1'b0;
      msg_ack   = 1'b0;
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      checks++;
      if ({msg_valid, err_valid, busy, err_code} !== 6'd0) begin
         failures++; $display("FAIL reset_flags got=%b want=000000", {msg_valid, err_valid, busy, err_code});
      end
      checks++;
      if ({msg_data, msg_len} !== 88'd0) begin
         failures++; $display("FAIL reset_msg got data=%h len=%h want 0", msg_data, msg_len);
      end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_nominal;
      seq_errs = 0;
      send_seq(0, {8'h7E, 8'h03, 8'h11}, 3);
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL nominal_busy got=%b want=1", busy); end
      send_seq(0, {8'h22, 8'h33, 8'h03}, 3);
      checks++;
      if (msg_valid !== 1'b1 || msg_len !== 8'd3) begin
         failures++; $display("FAIL nominal_valid got v=%b len=%0d want v=1 len=3", msg_valid, msg_len);
      end
      checks++;
      if (msg_data !== 80'h332211) begin failures++; $display("FAIL nominal_data got=%h want=332211", msg_data); end
      checks++;
      if (seq_errs !== 0 || busy !== 1'b0) begin
         failures++; $display("FAIL nominal_clean got errs=%0d busy=%b want 0 0", seq_errs, busy);
      end
      do_ack(0);
      checks++;
      if (msg_valid !== 1'b0) begin failures++; $display("FAIL nominal_ack got=%b want=0", msg_valid); end
   endtask

   task automatic test_escape;
      seq_errs = 0;
      send_seq(0, {8'h7E, 8'h02, 8'hFE, 8'h7E, 8'hFE, 8'hFE, 8'h03}, 7);
      checks++;
      if (msg_valid !== 1'b1 || msg_len !== 8'd2 || msg_data !== 80'hFE7E || seq_errs !== 0) begin
         failures++; $display("FAIL escape got v=%b len=%0d data=%h errs=%0d want 1 2 FE7E 0",
                              msg_valid, msg_len, msg_data, seq_errs);
      end
      do_ack(0);
   endtask

   task automatic test_checksum;
      seq_errs = 0;
      send_seq(1, {8'h7E, 8'h02, 8'h10, 8'h20, 8'h32, 8'h03}, 6);
      checks++;
      if (c_msg_valid !== 1'b1 || c_msg_len !== 8'd2 || c_msg_data !== 80'h2010 || seq_errs !== 0) begin
         failures++; $display("FAIL csum_good got v=%b len=%0d data=%h errs=%0d want 1 2 2010 0",
                              c_msg_valid, c_msg_len, c_msg_data, seq_errs);
      end
      do_ack(1);
      send_seq(1, {8'h7E, 8'h02, 8'h10, 8'h20, 8'h33}, 5);
      checks++;
      if (c_err_valid !== 1'b1 || c_err_code !== 3'd2) begin
         failures++; $display("FAIL csum_bad got ev=%b code=%0d want 1 2", c_err_valid, c_err_code);
      end
      send_byte(1, 8'h03);
      checks++;
      if (c_msg_valid !== 1'b0 || c_busy !== 1'b0) begin
         failures++; $display("FAIL csum_drop got v=%b busy=%b want 0 0", c_msg_valid, c_busy);
      end
   endtask

   task automatic test_overflow;
      send_seq(0, {8'h7E, 8'h0B}, 2);
      checks++;
      if (err_valid !== 1'b1 || err_code !== 3'd1 || busy !== 1'b0) begin
         failures++; $display("FAIL overflow got ev=%b code=%0d busy=%b want 1 1 0", err_valid, err_code, busy);
      end
      seq_errs = 0;
      send_seq(0, {8'h7E, 8'h0A, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08}, 10);
      send_seq(0, {8'h09, 8'h0A, 8'h03}, 3);
      checks++;
      if (msg_valid !== 1'b1 || msg_len !== 8'd10 || msg_data !== 80'h0A090807060504030201 || seq_errs !== 0) begin
         failures++; $display("FAIL max_len got v=%b len=%0d data=%h errs=%0d want 1 10 0A..01 0",
                              msg_valid, msg_len, msg_data, seq_errs);
      end
      do_ack(0);
   endtask

   task automatic test_resync;
      send_seq(0, {8'h7E, 8'h04, 8'hAA, 8'h7E}, 4);
      checks++;
      if (err_valid !== 1'b1 || err_code !== 3'd5 || busy !== 1'b1) begin
         failures++; $display("FAIL resync got ev=%b code=%0d busy=%b want 1 5 1", err_valid, err_code, busy);
      end
      seq_errs = 0;
      send_seq(0, {8'h01, 8'h55, 8'h03}, 3);
      checks++;
      if (msg_valid !== 1'b1 || msg_len !== 8'd1 || msg_data !== 80'h55 || seq_errs !== 0) begin
         failures++; $display("FAIL resync_msg got v=%b len=%0d data=%h errs=%0d want 1 1 55 0",
                              msg_valid, msg_len, msg_data, seq_errs);
      end
      do_ack(0);
   endtask

   task automatic test_timeout;
      int k;
      send_seq(0, {8'h7E, 8'h02, 8'hAA}, 3);
      k = 0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (err_valid) begin k = i; break; end
      end
      checks++;
      if (k !== 100 || err_code !== 3'd4 || busy !== 1'b0) begin
         failures++; $display("FAIL timeout got cycle=%0d code=%0d busy=%b want 100 4 0", k, err_code, busy);
      end
      seq_errs = 0;
      send_seq(0, {8'h7E, 8'h01, 8'h5A, 8'h03}, 4);
      checks++;
      if (msg_valid !== 1'b1 || msg_data !== 80'h5A || seq_errs !== 0) begin
         failures++; $display("FAIL timeout_recover got v=%b data=%h errs=%0d want 1 5A 0", msg_valid, msg_data, seq_errs);
      end
      do_ack(0);
   endtask

   task automatic test_overrun;
      send_seq(0, {8'h7E, 8'h01, 8'hA1, 8'h03}, 4);
      send_seq(0, {8'h7E, 8'h01, 8'hB2, 8'h03}, 4);
      checks++;
      if (err_valid !== 1'b1 || err_code !== 3'd6) begin
         failures++; $display("FAIL overrun got ev=%b code=%0d want 1 6", err_valid, err_code);
      end
      checks++;
      if (msg_valid !== 1'b1 || msg_data !== 80'hA1) begin
         failures++; $display("FAIL overrun_hold got v=%b data=%h want 1 A1", msg_valid, msg_data);
      end
   endtask

   task automatic test_ack_coincide;
      send_seq(0, {8'h7E, 8'h01, 8'hC3}, 3);
      @(negedge clk);
      in_data = 8'h03; in_valid = 1'b1; msg_ack = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; msg_ack = 1'b0;
      checks++;
      if (msg_valid !== 1'b1 || msg_data !== 80'hC3 || err_valid !== 1'b0) begin
         failures++; $display("FAIL ack_coincide got v=%b data=%h ev=%b want 1 C3 0", msg_valid, msg_data, err_valid);
      end
   endtask

   task automatic test_reset_mid;
      send_seq(0, {8'h7E, 8'h02, 8'hAA}, 3);
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({msg_valid, err_valid, busy, err_code} !== 6'd0 || {msg_data, msg_len} !== 88'd0) begin
         failures++; $display("FAIL reset_mid got v=%b busy=%b data=%h len=%0d want all 0",
                              msg_valid, busy, msg_data, msg_len);
      end
      @(negedge clk);
      reset = 1'b1;
      seq_errs = 0;
      send_seq(0, {8'h7E, 8'h01, 8'h66, 8'h03}, 4);
      checks++;
      if (msg_valid !== 1'b1 || msg_data !== 80'h66 || seq_errs !== 0) begin
         failures++; $display("FAIL reset_recover got v=%b data=%h errs=%0d want 1 66 0", msg_valid, msg_data, seq_errs);
      end
   endtask

   initial begin
      test_reset;
      test_nominal;
      test_escape;
      test_checksum;
      test_overflow;
      test_resync;
      test_timeout;
      test_overrun;
      test_ack_coincide;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rx_frame_decoder.md
Name: rx_frame_decoder

Overview:
- Parametrised successor to the in-top UART RX message decoder. Consumes de-serialised UART bytes, a one-cycle strobe per byte.
- Frame format: SYNC, count byte, payload, optional checksum, END. Escape handling applies throughout.
- Supports a configurable payload depth, a working inter-byte timeout, an optional checksum, explicit error reporting, and a double-buffered output with a valid/ack handshake toward the message handler.
- Sits between the UART unloader and the message handler, in the rx logic clock domain.

Parameters:
- MAX_BYTES, 10, payload buffer depth in bytes (1..255).
- SYNC_BYTE, 8'h7E, frame start marker.
- ESC_BYTE, 8'hFE, escape prefix. The next byte is taken literally.
- END_BYTE, 8'h03, frame terminator.
- CHECKSUM_EN, 0. When 1, a checksum byte is expected between the payload and END.
- TIMEOUT_CYCLES, 100, inter-byte timeout in clk cycles. 0 disables the timeout.

Ports:
- clk  input  1  rx logic clock.
- reset  input  1  asynchronous, active-low reset.
- in_data  input  8  received byte.
- in_valid  input  1  one-cycle strobe; in_data is accepted in this cycle.
- msg_data  output  8*MAX_BYTES  completed payload; byte i at [8i+7:8i]; unused bytes are 0.
- msg_len  output  8  payload byte count of the held message.
- msg_valid  output  1  held message available.
- msg_ack  input  1  consumer accepts the held message.
- err_valid  output  1  one-cycle error pulse.
- err_code  output  3  error cause, valid with err_valid: 1 OVERFLOW, 2 CHECKSUM, 3 FRAMING, 4 TIMEOUT, 5 RESYNC, 6 OVERRUN.
- busy  output  1  high when the state is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state goes to IDLE; the escape flag, working buffer, byte counters, checksum accumulator and timeout counter clear.
  - msg_data=0, msg_len=0, msg_valid=0, err_valid=0, err_code=0, busy=0.
  - A reset mid-frame discards the frame silently.
- Escape handling:
  - An unescaped ESC_BYTE only sets the escape flag. It causes no state change and is not stored.
  - The next accepted byte is literal (this includes SYNC, ESC and END) and the flag then clears.
  - An ESC received in IDLE is ignored and the flag stays clear.
- Resync: an unescaped SYNC_BYTE in any state does the following:
  - clears the working buffer and counters, zeroes the checksum, and moves to BCNT;
  - if the state was not IDLE, pulses err_code=RESYNC.
- States (advance only on accepted non-ESC, non-SYNC bytes):
  - IDLE: other bytes are ignored.
  - BCNT: the byte becomes the expected count N and is added to the checksum.
    - N > MAX_BYTES: OVERFLOW, go to IDLE.
    - N = 0: go to CSUM if CHECKSUM_EN, else TAIL.
    - Otherwise go to BODY.
  - BODY: store the byte at working[rcvd], increment rcvd, add it to the checksum. When rcvd reaches N, go to CSUM or TAIL.
  - CSUM: if the byte differs from the checksum (sum mod 256 of N and all payload bytes, de-escaped values), pulse CHECKSUM and go to IDLE; else go to TAIL.
  - TAIL: a byte other than END_BYTE pulses FRAMING and goes to IDLE. END_BYTE means the frame completes and the state goes to IDLE.
- Completion:
  - On the cycle after END is accepted: msg_data is loaded from the working buffer, msg_len=N, msg_valid=1.
  - msg_valid holds until msg_ack=1 is sampled; it clears on the next edge.
  - msg_ack is ignored while msg_valid=0.
  - If msg_valid=1 without a same-cycle msg_ack at completion, the new frame is dropped, the held message is unchanged, and OVERRUN is pulsed.
  - If msg_ack and completion coincide, the new frame loads and msg_valid stays 1.
- Timeout (when TIMEOUT_CYCLES>0):
  - The counter runs while the state is not IDLE and clears on every accepted byte, including ESC.
  - On reaching TIMEOUT_CYCLES: TIMEOUT is pulsed and the state goes to IDLE.
  - If a byte is accepted in the same cycle as the timeout, the byte wins and the counter clears.
- err_valid is a single-cycle pulse. If two errors coincide in one cycle, the lower code is reported.
- The working buffer is independent of msg_data. Receiving a frame never disturbs the held message.

Test Plan:
- Nominal frame: bytes 7E,03,11,22,33,03 -> one cycle after the 03 END byte, msg_valid=1, msg_len=3, msg_data[23:0]=33_22_11, higher bytes 0. msg_ack -> msg_valid=0 on the next edge.
- Escaped payload: bytes 7E,02,FE,7E,FE,FE,03 -> msg_len=2, bytes 7E,FE, no error.
- Count and checksum (CHECKSUM_EN=1):
  - 7E,02,10,20,32,03 -> valid message with checksum 02+10+20=32.
  - Checksum byte 33 instead -> err_code=2 pulse, msg_valid stays 0.
- Overflow and resync:
  - 7E,0B with MAX_BYTES=10 -> err_code=1.
  - 7E,04,AA,7E,01,55,03 -> RESYNC pulse (code 5), then a valid message msg_len=1 with data 55.
- Timeout: 7E,02,AA, then no in_valid for 100 cycles -> err_code=4, busy=0. A following full frame decodes correctly.
- Overrun and reset:
  - A second complete frame while the first is unacked -> err_code=6, first data retained.
  - Ack in the same cycle as the second completion -> second data loaded.
  - reset low mid-body -> all outputs 0 immediately.
